// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and defaults for the SRAM access arbiter between the Sobel
// fetch reader and the edge output buffer writer.
package sram_access_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_WRITE,
        ARB_STATUS,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        OWN_READ  = 1'b0,
        OWN_WRITE = 1'b1
    } owner_t;

    localparam int STATUS_ADDR_DEF = 4;
    localparam int STATUS_VAL_DEF  = 1;

    // Width of a counter that must hold 0..max_burst inclusive.
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Reader, writer and SRAM-side signals of the arbiter; the slave modport is
// the arbiter's view, master is the view of the clients plus the SRAM.
interface sram_access_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_grant;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_grant;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read;
    logic              mem_write;
    logic              mem_ready;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata, mem_ready,
        input  rd_grant, rd_data, rd_valid, wr_grant,
               mem_addr, mem_wdata, mem_read, mem_write
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata, mem_ready,
        output rd_grant, rd_data, rd_valid, wr_grant,
               mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/sram_access_arbiter_fairness.sv
// Read/write pick for the SRAM arbiter: the current owner keeps the port while
// both sides request, until it has had MAX_BURST grants in a row.
module sram_arb_fairness
    import sram_access_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rd_req,
    input  logic wr_req,
    input  logic done_latch,
    input  logic grant_rd,
    input  logic grant_wr,
    output logic pick_write
);
    localparam int CNT_W = burst_cnt_w(MAX_BURST);

    logic [CNT_W-1:0] burst_cnt;
    owner_t           last_owner;
    owner_t           grant_owner;
    logic             exhausted;
    logic             favour_write;

    always_comb begin
        exhausted    = (burst_cnt == CNT_W'(MAX_BURST));
        // No history yet (count 0) defaults to the writer.
        favour_write = exhausted ? (last_owner == OWN_READ)
                                 : (burst_cnt == '0 || last_owner == OWN_WRITE);
        pick_write   = wr_req && (done_latch || !rd_req || favour_write);
        grant_owner  = grant_wr ? OWN_WRITE : OWN_READ;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            burst_cnt  <= '0;
            last_owner <= OWN_READ;
        end else if (grant_rd || grant_wr) begin
            if (grant_owner == last_owner) begin
                if (!exhausted) burst_cnt <= burst_cnt + 1'b1;
            end else begin
                burst_cnt <= CNT_W'(1);
            end
            last_owner <= grant_owner;
        end
    end
endmodule

// File: rtl/sram_access_arbiter.sv
// Single-port SRAM arbiter: one access at a time, controls held until
// mem_ready; after img_done, drains writes and then writes the status flag.
module sram_access_arbiter
    import sram_access_arbiter_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                MAX_BURST   = 4,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_ADDR_DEF),
    parameter logic [DATA_W-1:0] STATUS_VAL  = DATA_W'(STATUS_VAL_DEF)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    sram_access_arbiter_if.slave  bus,
    input  logic                  img_done,
    output logic                  busy,
    output logic                  done
);
    arb_state_t state;
    logic       done_latch;
    logic       pick_write;
    logic       go_wr;
    logic       go_rd;

    // Grant decisions use the registered done_latch, so a read granted on the
    // same edge img_done arrives still completes.
    always_comb begin
        go_wr = (state == ARB_IDLE) && pick_write;
        go_rd = (state == ARB_IDLE) && bus.rd_req && !done_latch && !pick_write;
    end

    assign busy = (state != ARB_IDLE) && (state != ARB_DONE);

    sram_arb_fairness #(.MAX_BURST(MAX_BURST)) u_fair (
        .clk        (clk),
        .n_rst      (n_rst),
        .rd_req     (bus.rd_req),
        .wr_req     (bus.wr_req),
        .done_latch (done_latch),
        .grant_rd   (go_rd),
        .grant_wr   (go_wr),
        .pick_write (pick_write)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= ARB_IDLE;
            done_latch    <= 1'b0;
            done          <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.rd_grant  <= 1'b0;
            bus.wr_grant  <= 1'b0;
            bus.rd_data   <= '0;
            bus.rd_valid  <= 1'b0;
        end else begin
            bus.rd_grant <= 1'b0;
            bus.wr_grant <= 1'b0;
            bus.rd_valid <= 1'b0;
            if (img_done) done_latch <= 1'b1;

            case (state)
                ARB_IDLE: begin
                    if (go_wr) begin
                        bus.mem_addr  <= bus.wr_addr;
                        bus.mem_wdata <= bus.wr_data;
                        bus.mem_write <= 1'b1;
                        bus.wr_grant  <= 1'b1;
                        state         <= ARB_WRITE;
                    end else if (go_rd) begin
                        bus.mem_addr  <= bus.rd_addr;
                        bus.mem_read  <= 1'b1;
                        bus.rd_grant  <= 1'b1;
                        state         <= ARB_READ;
                    end else if (done_latch) begin
                        bus.mem_addr  <= STATUS_ADDR;
                        bus.mem_wdata <= STATUS_VAL;
                        bus.mem_write <= 1'b1;
                        state         <= ARB_STATUS;
                    end
                end
                ARB_READ: begin
                    if (bus.mem_ready) begin
                        bus.mem_read <= 1'b0;
                        bus.rd_data  <= bus.mem_rdata;
                        bus.rd_valid <= 1'b1;
                        state        <= ARB_IDLE;
                    end
                end
                ARB_WRITE: begin
                    if (bus.mem_ready) begin
                        bus.mem_write <= 1'b0;
                        state         <= ARB_IDLE;
                    end
                end
                ARB_STATUS: begin
                    if (bus.mem_ready) begin
                        bus.mem_write <= 1'b0;
                        done          <= 1'b1;
                        state         <= ARB_DONE;
                    end
                end
                ARB_DONE: ;
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed scenarios plus a randomized phase checked against a grant-history
// model of the arbiter's ordering rules.
module tb_sram_access_arbiter;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic n_rst, img_done, busy, done;
    logic use_fn;
    logic [31:0] rdata_fixed;
    int ntests = 0;
    int nfail  = 0;
    bit hist[$];

    // randomized-phase state
    bit rd_pend, wr_pend, inflight, ifl_wr, rd_outst, ready_seen, exp_w, found;
    logic [31:0] r_addr, w_addr, w_data, ifl_addr, ifl_data, rd_exp;
    int rd_wait, wr_wait, max_wait, n_gr, nwg, nrg;
    byte got[$];
    string exp_order;

    sram_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif();

    sram_access_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB),
        .STATUS_ADDR(32'd4), .STATUS_VAL(32'd1)
    ) dut (
        .clk(clk), .n_rst(n_rst), .bus(bif),
        .img_done(img_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    always_comb bif.mem_rdata = use_fn ? rfn(bif.mem_addr) : rdata_fixed;

    // Owner that should win when both sides request, from the grant history.
    function automatic bit model_pick();
        int run;
        bit last;
        if (hist.size() == 0) return 1'b1;
        last = hist[hist.size()-1];
        run  = 0;
        for (int i = hist.size() - 1; i >= 0 && run < MAXB; i--) begin
            if (hist[i] != last) break;
            run++;
        end
        return (run >= MAXB) ? !last : last;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bif.rd_req = 1'b0;
        bif.wr_req = 1'b0;
        img_done   = 1'b0;
        n_rst      = 1'b0;
        tick();
        n_rst = 1'b1;
        hist.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0; img_done = 1'b0; use_fn = 1'b0; rdata_fixed = '0;
        bif.rd_req = 0; bif.rd_addr = '0; bif.wr_req = 0; bif.wr_addr = '0;
        bif.wr_data = '0; bif.mem_ready = 1'b0;
        tick(); tick();
        chk("rst_mem_read", bif.mem_read, 0);
        chk("rst_mem_write", bif.mem_write, 0);
        chk("rst_mem_addr", bif.mem_addr, 0);
        chk("rst_grants", {bif.rd_grant, bif.wr_grant}, 0);
        chk("rst_rd_valid_data", {bif.rd_valid, bif.rd_data}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        n_rst = 1'b1;

        // 1: single read, zero wait states
        bif.rd_req = 1; bif.rd_addr = 32'h100; bif.mem_ready = 1; rdata_fixed = 32'hA5A5_A5A5;
        tick();
        chk("t1_rd_grant", bif.rd_grant, 1);
        chk("t1_mem_read", bif.mem_read, 1);
        chk("t1_mem_addr", bif.mem_addr, 32'h100);
        chk("t1_mem_write", bif.mem_write, 0);
        chk("t1_busy", busy, 1);
        bif.rd_req = 0;
        tick();
        chk("t1_grant_drop", bif.rd_grant, 0);
        chk("t1_read_drop", bif.mem_read, 0);
        chk("t1_rd_valid", bif.rd_valid, 1);
        chk("t1_rd_data", bif.rd_data, 32'hA5A5_A5A5);
        tick();
        chk("t1_valid_pulse", bif.rd_valid, 0);

        // 2: both requesting continuously -> bursts of MAXB
        do_reset();
        bif.rd_req = 1; bif.rd_addr = 32'h10; bif.wr_req = 1; bif.wr_addr = 32'h20;
        bif.wr_data = 32'h99; bif.mem_ready = 1;
        exp_order = "WWWWRRRRW";
        for (int c = 0; c < 60 && got.size() < 9; c++) begin
            tick();
            chk("t2_excl", bif.mem_read & bif.mem_write, 0);
            if (bif.wr_grant) got.push_back("W");
            else if (bif.rd_grant) got.push_back("R");
        end
        bif.rd_req = 0; bif.wr_req = 0;
        chk("t2_count", got.size(), 9);
        for (int i = 0; i < got.size() && i < 9; i++)
            chk($sformatf("t2_grant%0d", i), got[i], exp_order[i]);
        tick(); tick();

        // 3: write held through 5 wait-state cycles
        nwg = 0;
        bif.wr_req = 1; bif.wr_addr = 32'h2000; bif.wr_data = 32'hFFFF_0000; bif.mem_ready = 0;
        tick();
        chk("t3_wr_grant", bif.wr_grant, 1);
        nwg += int'(bif.wr_grant);
        bif.wr_req = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                tick();
                nwg += int'(bif.wr_grant);
            end
            chk($sformatf("t3_write_c%0d", i), bif.mem_write, 1);
            chk($sformatf("t3_addr_c%0d", i), bif.mem_addr, 32'h2000);
            chk($sformatf("t3_data_c%0d", i), bif.mem_wdata, 32'hFFFF_0000);
        end
        bif.mem_ready = 1;
        tick();
        chk("t3_release", bif.mem_write, 0);
        chk("t3_one_grant", nwg, 1);

        // randomized traffic against the history model
        do_reset();
        use_fn = 1;
        rd_pend = 0; wr_pend = 0; inflight = 0; rd_outst = 0;
        rd_wait = 0; wr_wait = 0; max_wait = 0; n_gr = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            ready_seen = bif.mem_ready;
            chk("r_excl", bif.mem_read & bif.mem_write, 0);
            if (bif.rd_valid) begin
                chk("r_valid_expected", rd_outst, 1);
                chk("r_rd_data", bif.rd_data, rd_exp);
                rd_outst = 0;
            end
            if (inflight) begin
                chk("r_grant_while_busy", bif.rd_grant | bif.wr_grant, 0);
                if (ready_seen) begin
                    chk("r_release", bif.mem_read | bif.mem_write, 0);
                    inflight = 0;
                end else begin
                    chk("r_hold_strobe", ifl_wr ? bif.mem_write : bif.mem_read, 1);
                    chk("r_hold_addr", bif.mem_addr, ifl_addr);
                    if (ifl_wr) chk("r_hold_data", bif.mem_wdata, ifl_data);
                end
            end else if (bif.rd_grant | bif.wr_grant) begin
                chk("r_one_grant", bif.rd_grant & bif.wr_grant, 0);
                chk("r_grant_had_req", rd_pend | wr_pend, 1);
                exp_w = (rd_pend && wr_pend) ? model_pick() : wr_pend;
                chk("r_owner", bif.wr_grant, exp_w);
                n_gr++;
                inflight = 1;
                ifl_wr = bif.wr_grant;
                if (bif.wr_grant) begin
                    chk("r_wr_strobe", bif.mem_write, 1);
                    chk("r_wr_addr", bif.mem_addr, w_addr);
                    chk("r_wr_data", bif.mem_wdata, w_data);
                    ifl_addr = w_addr; ifl_data = w_data;
                    wr_pend = 0;
                    hist.push_back(1'b1);
                end else begin
                    chk("r_rd_strobe", bif.mem_read, 1);
                    chk("r_rd_addr", bif.mem_addr, r_addr);
                    ifl_addr = r_addr;
                    rd_pend = 0; rd_outst = 1; rd_exp = rfn(r_addr);
                    hist.push_back(1'b0);
                end
            end
            if (rd_pend) rd_wait++;
            if (wr_pend) wr_wait++;
            if (rd_wait > max_wait) max_wait = rd_wait;
            if (wr_wait > max_wait) max_wait = wr_wait;
            if (!rd_pend && $urandom_range(0, 2) == 0) begin
                rd_pend = 1; r_addr = $urandom; rd_wait = 0;
            end
            if (!wr_pend && $urandom_range(0, 2) == 0) begin
                wr_pend = 1; w_addr = $urandom; w_data = $urandom; wr_wait = 0;
            end
            bif.rd_req = rd_pend; bif.rd_addr = r_addr;
            bif.wr_req = wr_pend; bif.wr_addr = w_addr; bif.wr_data = w_data;
            bif.mem_ready = ($urandom_range(0, 3) != 0);
        end
        bif.rd_req = 0; bif.wr_req = 0; bif.mem_ready = 1;
        repeat (4) tick();
        chk("r_enough_grants", n_gr > 100, 1);
        chk("r_max_wait", max_wait <= 100, 1);

        // 4: img_done with both pending -> drain write, skip read, status write
        do_reset();
        use_fn = 0;
        bif.rd_req = 1; bif.rd_addr = 32'h40;
        bif.wr_req = 1; bif.wr_addr = 32'h80; bif.wr_data = 32'hBEEF;
        img_done = 1; bif.mem_ready = 1;
        tick();
        chk("t4_wr_grant", bif.wr_grant, 1);
        chk("t4_no_rd_grant", bif.rd_grant, 0);
        img_done = 0; bif.wr_req = 0;
        found = 0; nrg = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            nrg += int'(bif.rd_grant);
            if (bif.mem_write && bif.mem_addr == 32'd4) begin
                found = 1;
                chk("t4_status_data", bif.mem_wdata, 32'd1);
                chk("t4_status_busy", busy, 1);
            end
        end
        chk("t4_status_seen", found, 1);
        chk("t4_read_never", nrg, 0);
        tick();
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_write_drop", bif.mem_write, 0);
        bif.wr_req = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_done_grants", {bif.rd_grant, bif.wr_grant}, 0);
            chk("t4_done_strobes", {bif.mem_read, bif.mem_write}, 0);
            chk("t4_done_held", done, 1);
        end
        bif.rd_req = 0; bif.wr_req = 0;

        // 5: reset in the middle of a stalled write
        n_rst = 0;
        tick();
        chk("t5_done_cleared", done, 0);
        n_rst = 1;
        bif.wr_req = 1; bif.wr_addr = 32'h500; bif.wr_data = 32'h55; bif.mem_ready = 0;
        tick();
        chk("t5_wr_grant", bif.wr_grant, 1);
        bif.wr_req = 0;
        tick();
        chk("t5_write_held", bif.mem_write, 1);
        n_rst = 0;
        tick();
        chk("t5_rst_write", bif.mem_write, 0);
        chk("t5_rst_addr", bif.mem_addr, 0);
        chk("t5_rst_wdata", bif.mem_wdata, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_pulses", {bif.rd_grant, bif.wr_grant, bif.rd_valid}, 0);
        n_rst = 1;
        bif.rd_req = 1; bif.rd_addr = 32'h300; bif.mem_ready = 1; rdata_fixed = 32'h1234_5678;
        tick();
        chk("t5_rd_grant", bif.rd_grant, 1);
        chk("t5_mem_read", bif.mem_read, 1);
        chk("t5_mem_addr", bif.mem_addr, 32'h300);
        bif.rd_req = 0;
        tick();
        chk("t5_rd_valid", bif.rd_valid, 1);
        chk("t5_rd_data", bif.rd_data, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
